// File: rtl/sap_pkg.sv
// Shared SAP-1 definitions: control-word bit positions, opcodes and default widths.
// The controller imports the same bit indices so both ends of the control word agree.
package sap_pkg;

    localparam int SAP_DATA_W = 8;
    localparam int SAP_ADDR_W = 4;
    localparam int SAP_CTRL_W = 16;

    localparam int C_HLT = 0;
    localparam int C_MI  = 1;
    localparam int C_RO  = 2;
    localparam int C_RI  = 3;
    localparam int C_IO  = 4;
    localparam int C_II  = 5;
    localparam int C_AO  = 6;
    localparam int C_AI  = 7;
    localparam int C_EO  = 8;
    localparam int C_SU  = 9;
    localparam int C_BI  = 10;
    localparam int C_OI  = 11;
    localparam int C_CE  = 12;
    localparam int C_CO  = 13;
    localparam int C_J   = 14;
    localparam int C_FI  = 15;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_JC  = 4'h7,
        OP_JZ  = 4'h8,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

endpackage

// File: rtl/sap_alu.sv
// Combinational SAP-1 adder/subtractor; subtract uses two's complement of B,
// so carry=1 on subtract means no borrow.
module sap_alu
    import sap_pkg::*;
#(
    parameter int DATA_W = SAP_DATA_W
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic              i_sub,
    output logic [DATA_W-1:0] o_result,
    output logic              o_carry,
    output logic              o_zero
);

    logic [DATA_W:0] w_b_op;
    logic [DATA_W:0] w_sum;

    assign w_b_op   = i_sub ? ({1'b0, ~i_b} + (DATA_W+1)'(1)) : {1'b0, i_b};
    assign w_sum    = {1'b0, i_a} + w_b_op;
    assign o_result = w_sum[DATA_W-1:0];
    assign o_carry  = w_sum[DATA_W];
    assign o_zero   = (w_sum[DATA_W-1:0] == '0);

endmodule

// File: rtl/sap_datapath.sv
// SAP-1 datapath: shared bus, PC/MAR/RAM/IR/A/B/OUT/flags, driven by the controller's
// control word, with a program-load port for filling RAM before execution.
module sap_datapath
    import sap_pkg::*;
#(
    parameter int DATA_W = SAP_DATA_W,
    parameter int ADDR_W = SAP_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [SAP_CTRL_W-1:0] ctrl,
    output logic [3:0]            opcode,
    output logic                  flag_c,
    output logic                  flag_z,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_valid,
    output logic                  halted,
    output logic                  bus_conflict,
    input  logic                  prog_en,
    input  logic                  prog_we,
    input  logic [ADDR_W-1:0]     prog_addr,
    input  logic [DATA_W-1:0]     prog_data,
    output logic [DATA_W-1:0]     bus_dbg
);

    localparam int DEPTH = 2**ADDR_W;

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_mar;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_out;
    logic              r_flag_c;
    logic              r_flag_z;
    logic              r_out_valid;
    logic              r_halted;
    logic              r_conflict;
    logic [DATA_W-1:0] r_ram [DEPTH];

    logic [SAP_CTRL_W-1:0] w_ctrl;
    logic [4:0]            w_drv;
    logic                  w_conflict;
    logic                  w_ld;
    logic [DATA_W-1:0]     w_bus;
    logic [DATA_W-1:0]     w_alu_result;
    logic                  w_alu_carry;
    logic                  w_alu_zero;
    logic                  w_ram_we;
    logic [ADDR_W-1:0]     w_ram_addr;
    logic [DATA_W-1:0]     w_ram_wdata;

    // Program mode masks the whole control word, so the exit edge cannot load anything.
    assign w_ctrl     = prog_en ? '0 : ctrl;
    assign w_drv      = {w_ctrl[C_EO], w_ctrl[C_AO], w_ctrl[C_IO], w_ctrl[C_RO], w_ctrl[C_CO]};
    assign w_conflict = (w_drv & (w_drv - 5'd1)) != 5'd0;
    assign w_ld       = ~r_halted;

    sap_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_sub    (w_ctrl[C_SU]),
        .o_result (w_alu_result),
        .o_carry  (w_alu_carry),
        .o_zero   (w_alu_zero)
    );

    // Anything other than exactly one driver leaves the bus at zero.
    always_comb begin
        w_bus = '0;
        case (w_drv)
            5'b00001: w_bus = {{(DATA_W-ADDR_W){1'b0}}, r_pc};
            5'b00010: w_bus = r_ram[r_mar];
            5'b00100: w_bus = {{(DATA_W-4){1'b0}}, r_ir[3:0]};
            5'b01000: w_bus = r_a;
            5'b10000: w_bus = w_alu_result;
            default:  w_bus = '0;
        endcase
    end

    assign w_ram_we    = (prog_en & prog_we) | (w_ld & w_ctrl[C_RI]);
    assign w_ram_addr  = prog_en ? prog_addr : r_mar;
    assign w_ram_wdata = prog_en ? prog_data : w_bus;

    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_ram[w_ram_addr] <= w_ram_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= '0;
            r_mar       <= '0;
            r_ir        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_out       <= '0;
            r_flag_c    <= 1'b0;
            r_flag_z    <= 1'b0;
            r_out_valid <= 1'b0;
            r_halted    <= 1'b0;
            r_conflict  <= 1'b0;
        end else begin
            r_out_valid <= w_ld & w_ctrl[C_OI];
            if (w_conflict)     r_conflict <= 1'b1;
            if (w_ctrl[C_HLT])  r_halted   <= 1'b1;
            if (w_ld) begin
                if (w_ctrl[C_MI]) r_mar <= w_bus[ADDR_W-1:0];
                if (w_ctrl[C_II]) r_ir  <= w_bus;
                if (w_ctrl[C_AI]) r_a   <= w_bus;
                if (w_ctrl[C_BI]) r_b   <= w_bus;
                if (w_ctrl[C_OI]) r_out <= w_bus;
                if (w_ctrl[C_J]) begin
                    r_pc <= w_bus[ADDR_W-1:0];
                end else if (w_ctrl[C_CE]) begin
                    r_pc <= r_pc + ADDR_W'(1);
                end
                if (w_ctrl[C_FI]) begin
                    r_flag_c <= w_alu_carry;
                    r_flag_z <= w_alu_zero;
                end
            end
        end
    end

    assign opcode       = r_ir[DATA_W-1 -: 4];
    assign flag_c       = r_flag_c;
    assign flag_z       = r_flag_z;
    assign out_data     = r_out;
    assign out_valid    = r_out_valid;
    assign halted       = r_halted;
    assign bus_conflict = r_conflict;
    assign bus_dbg      = w_bus;

endmodule

// File: tb/tb_sap_datapath.sv
// Self-checking bench for sap_datapath: directed program/ALU/PC/halt/reset sequences
// plus randomized control words checked against a behavioural model.
`timescale 1ns/1ps
module tb_sap_datapath;
    import sap_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] ctrl;
    logic [3:0]  opcode;
    logic        flag_c, flag_z;
    logic [7:0]  out_data;
    logic        out_valid, halted, bus_conflict;
    logic        prog_en, prog_we;
    logic [3:0]  prog_addr;
    logic [7:0]  prog_data;
    logic [7:0]  bus_dbg;

    int checks = 0;
    int failures = 0;

    sap_datapath dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ctrl         (ctrl),
        .opcode       (opcode),
        .flag_c       (flag_c),
        .flag_z       (flag_z),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .halted       (halted),
        .bus_conflict (bus_conflict),
        .prog_en      (prog_en),
        .prog_we      (prog_we),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data),
        .bus_dbg      (bus_dbg)
    );

    always #5 clk = ~clk;

    localparam logic [15:0] HLT = 16'h1 << C_HLT;
    localparam logic [15:0] MI  = 16'h1 << C_MI;
    localparam logic [15:0] RO  = 16'h1 << C_RO;
    localparam logic [15:0] RI  = 16'h1 << C_RI;
    localparam logic [15:0] IO  = 16'h1 << C_IO;
    localparam logic [15:0] II  = 16'h1 << C_II;
    localparam logic [15:0] AO  = 16'h1 << C_AO;
    localparam logic [15:0] AI  = 16'h1 << C_AI;
    localparam logic [15:0] EO  = 16'h1 << C_EO;
    localparam logic [15:0] SU  = 16'h1 << C_SU;
    localparam logic [15:0] BI  = 16'h1 << C_BI;
    localparam logic [15:0] OI  = 16'h1 << C_OI;
    localparam logic [15:0] CE  = 16'h1 << C_CE;
    localparam logic [15:0] CO  = 16'h1 << C_CO;
    localparam logic [15:0] J   = 16'h1 << C_J;
    localparam logic [15:0] FI  = 16'h1 << C_FI;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic [7:0] exp_res;
        logic       exp_c;
        logic       exp_z;
    } alu_vec_t;

    // Behavioural model state
    logic [3:0] m_pc, m_mar;
    logic [7:0] m_ir, m_a, m_b, m_out;
    logic       m_c, m_z, m_ov, m_halt, m_conf;
    logic [7:0] m_ram [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic [15:0] c);
        ctrl = c;
        @(posedge clk);
        #1;
        ctrl = '0;
    endtask

    task automatic peek(input logic [15:0] c, output logic [7:0] v);
        ctrl = c;
        #1;
        v = bus_dbg;
        ctrl = '0;
    endtask

    task automatic prog_write(input logic [3:0] a, input logic [7:0] d);
        prog_en = 1'b1; prog_we = 1'b1; prog_addr = a; prog_data = d;
        @(posedge clk);
        #1;
        prog_en = 1'b0; prog_we = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        #1;
    endtask

    function automatic logic [7:0] m_alu(input logic sub, output logic c, output logic z);
        int s;
        s = sub ? int'(m_a) + 256 - int'(m_b) : int'(m_a) + int'(m_b);
        c = s[8];
        z = (s[7:0] == 8'h00);
        return s[7:0];
    endfunction

    function automatic logic [7:0] m_bus(input logic [15:0] c, input logic pe);
        logic [4:0] d;
        logic cc, zz;
        logic [7:0] r;
        d = pe ? 5'd0 : {c[C_EO], c[C_AO], c[C_IO], c[C_RO], c[C_CO]};
        r = m_alu(c[C_SU], cc, zz);
        if ($countones(d) != 1) return 8'h00;
        if (d[0]) return {4'h0, m_pc};
        if (d[1]) return m_ram[m_mar];
        if (d[2]) return {4'h0, m_ir[3:0]};
        if (d[3]) return m_a;
        return r;
    endfunction

    task automatic m_reset();
        m_pc = 0; m_mar = 0; m_ir = 0; m_a = 0; m_b = 0; m_out = 0;
        m_c = 0; m_z = 0; m_ov = 0; m_halt = 0; m_conf = 0;
    endtask

    task automatic m_step(input logic [15:0] c, input logic pe, input logic pw,
                          input logic [3:0] pa, input logic [7:0] pd);
        logic [7:0] bus;
        logic       we, ac, az;
        int         n;
        n   = pe ? 0 : $countones({c[C_EO], c[C_AO], c[C_IO], c[C_RO], c[C_CO]});
        bus = m_bus(c, pe);
        void'(m_alu(c[C_SU], ac, az));
        we  = !pe && !m_halt;
        if (n > 1) m_conf = 1;
        m_ov = we && c[C_OI];
        if (pe && pw) m_ram[pa] = pd;
        if (we) begin
            if (c[C_RI]) m_ram[m_mar] = bus;
            if (c[C_MI]) m_mar = bus[3:0];
            if (c[C_II]) m_ir = bus;
            if (c[C_AI]) m_a = bus;
            if (c[C_BI]) m_b = bus;
            if (c[C_OI]) m_out = bus;
            if (c[C_J]) m_pc = bus[3:0];
            else if (c[C_CE]) m_pc = m_pc + 4'd1;
            if (c[C_FI]) begin m_c = ac; m_z = az; end
        end
        if (!pe && c[C_HLT]) m_halt = 1;
    endtask

    function automatic logic [31:0] dut_state();
        return {14'd0, opcode, flag_c, flag_z, out_data, out_valid, halted, bus_conflict};
    endfunction

    function automatic logic [31:0] model_state();
        return {14'd0, m_ir[7:4], m_c, m_z, m_out, m_ov, m_halt, m_conf};
    endfunction

    initial begin
        logic [7:0]  v;
        logic [15:0] prog_seq [15];
        alu_vec_t    alu_tab [6];
        int          pulses;

        rst_n = 1'b0; ctrl = '0; prog_en = 0; prog_we = 0; prog_addr = 0; prog_data = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        chk("rst_opcode", opcode, 4'h0);
        chk("rst_flags", {flag_c, flag_z}, 2'b00);
        chk("rst_out", {out_data, out_valid}, 9'h0);
        chk("rst_halt_conf", {halted, bus_conflict}, 2'b00);
        peek(CO, v); chk("rst_pc", v, 8'h00);
        peek(AO, v); chk("rst_a", v, 8'h00);
        peek(16'h0, v); chk("idle_bus", v, 8'h00);

        // LDA E / ADD F / OUT / HLT program
        prog_write(4'h0, 8'h1E); prog_write(4'h1, 8'h2F); prog_write(4'h2, 8'hE0);
        prog_write(4'h3, 8'hF0); prog_write(4'hE, 8'h1C); prog_write(4'hF, 8'h0E);
        prog_seq = '{CO|MI, RO|II|CE, IO|MI, RO|AI,
                     CO|MI, RO|II|CE, IO|MI, RO|BI, EO|AI|FI,
                     CO|MI, RO|II|CE, AO|OI,
                     CO|MI, RO|II|CE, HLT};
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            step(prog_seq[i]);
            if (out_valid) pulses++;
            if (i == 11) chk("out_valid_after_oi", out_valid, 1'b1);
        end
        for (int i = 0; i < 3; i++) begin
            step(16'h0);
            if (out_valid) pulses++;
        end
        chk("prog_out_data", out_data, 8'h2A);
        chk("prog_pulses", pulses, 1);
        chk("prog_halted", halted, 1'b1);
        chk("prog_flags", {flag_c, flag_z}, 2'b00);
        chk("prog_opcode", opcode, 4'hF);
        chk("prog_no_conflict", bus_conflict, 1'b0);

        // Halted: loads suppressed, program port still works, bus still shows drivers
        prog_write(4'h4, 8'h77);
        step(CO|MI);
        step(RO|AI);
        step(CE);
        peek(AO, v); chk("halt_a_kept", v, 8'h2A);
        peek(RO, v); chk("halt_mar_kept", v, 8'hF0);
        peek(CO, v); chk("halt_pc_kept", v, 8'h04);

        do_reset();
        chk("rst2_state", dut_state(), 32'h0);
        peek(CO, v); chk("rst2_pc", v, 8'h00);
        peek(AO, v); chk("rst2_a", v, 8'h00);
        peek(RO, v); chk("rst2_ram0_kept", v, 8'h1E);
        for (int i = 0; i < 4; i++) step(CE);
        step(CO|MI);
        peek(RO, v); chk("ram4_halted_write", v, 8'h77);

        // ALU table (MAR parked at 0 after reset)
        do_reset();
        alu_tab = '{'{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0},
                    '{8'h07, 8'h07, 1'b1, 8'h00, 1'b1, 1'b1},
                    '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1},
                    '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0},
                    '{8'h20, 8'h00, 1'b1, 8'h20, 1'b1, 1'b0},
                    '{8'h80, 8'h81, 1'b0, 8'h01, 1'b1, 1'b0}};
        for (int i = 0; i < 6; i++) begin
            prog_write(4'h0, alu_tab[i].a);
            step(RO|AI);
            prog_write(4'h0, alu_tab[i].b);
            step(RO|BI);
            step(EO|AI|FI|(alu_tab[i].sub ? SU : 16'h0));
            peek(AO, v);
            chk($sformatf("alu%0d_result", i), v, alu_tab[i].exp_res);
            chk($sformatf("alu%0d_flags", i), {flag_c, flag_z}, {alu_tab[i].exp_c, alu_tab[i].exp_z});
        end

        // PC wrap and J-over-CE
        do_reset();
        for (int i = 0; i < 15; i++) step(CE);
        peek(CO, v); chk("pc_at_f", v, 8'h0F);
        step(CE);
        peek(CO, v); chk("pc_wrap", v, 8'h00);
        prog_write(4'h0, 8'h59);
        step(RO|II);
        chk("ir_opcode", opcode, 4'h5);
        for (int i = 0; i < 3; i++) step(CE);
        peek(CO, v); chk("pc_at_3", v, 8'h03);
        step(IO|J|CE);
        peek(CO, v); chk("j_wins", v, 8'h09);

        // Bus conflict, sticky
        ctrl = AO|RO;
        #1;
        chk("conflict_bus", bus_dbg, 8'h00);
        @(posedge clk);
        #1;
        ctrl = '0;
        chk("conflict_set", bus_conflict, 1'b1);
        step(16'h0); step(CO);
        chk("conflict_sticky", bus_conflict, 1'b1);

        // Async reset mid-LDA
        do_reset();
        prog_write(4'h0, 8'h1E);
        step(RO|AI);
        step(AO|OI);
        chk("pre_out", out_data, 8'h1E);
        step(CO|MI); step(RO|II|CE); step(IO|MI);
        chk("pre_opcode", opcode, 4'h1);
        peek(RO, v); chk("pre_mar_e", v, 8'h1C);
        ctrl = RO|AI;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_state", dut_state(), 32'h0);
        chk("async_mar_cleared", bus_dbg, 8'h1E);
        ctrl = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        peek(AO, v); chk("async_a_zero", v, 8'h00);
        peek(CO, v); chk("async_pc_zero", v, 8'h00);

        // Randomized control words against the model
        do_reset();
        m_reset();
        for (int i = 0; i < 16; i++) begin
            m_ram[i] = 8'($urandom);
            prog_write(4'(i), m_ram[i]);
        end
        for (int cyc = 0; cyc < 800; cyc++) begin
            logic [15:0] c;
            int          r;
            logic [4:0]  drv_bits [5];
            if (cyc % 160 == 159) begin
                do_reset();
                m_reset();
            end
            drv_bits = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4};
            c = '0;
            r = int'($urandom_range(0, 15));
            if (r < 10) begin
                c[C_CO + 0] = 1'b0;
                case ($urandom_range(0, 4))
                    0: c = c | CO;
                    1: c = c | RO;
                    2: c = c | IO;
                    3: c = c | AO;
                    default: c = c | EO;
                endcase
            end else if (r >= 14) begin
                c = c | (($urandom_range(0, 1) == 0) ? (AO|EO) : (CO|RO));
            end
            if ($urandom_range(0, 2) == 0) c = c | MI;
            if ($urandom_range(0, 3) == 0) c = c | RI;
            if ($urandom_range(0, 2) == 0) c = c | II;
            if ($urandom_range(0, 2) == 0) c = c | AI;
            if ($urandom_range(0, 2) == 0) c = c | BI;
            if ($urandom_range(0, 3) == 0) c = c | OI;
            if ($urandom_range(0, 3) == 0) c = c | J;
            if ($urandom_range(0, 1) == 0) c = c | CE;
            if ($urandom_range(0, 2) == 0) c = c | FI;
            if ($urandom_range(0, 1) == 0) c = c | SU;
            if ($urandom_range(0, 99) == 0) c = c | HLT;
            ctrl      = c;
            prog_en   = ($urandom_range(0, 7) == 0);
            prog_we   = 1'($urandom);
            prog_addr = 4'($urandom);
            prog_data = 8'($urandom);
            #1;
            chk($sformatf("rand_bus_c%0d", cyc), bus_dbg, m_bus(c, prog_en));
            m_step(c, prog_en, prog_we, prog_addr, prog_data);
            @(posedge clk);
            #1;
            ctrl = '0; prog_en = 0; prog_we = 0;
            chk($sformatf("rand_state_c%0d", cyc), dut_state(), model_state());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
